key_pio_debounced: RTL and testbench

Parametrised Avalon-MM input PIO for the board's push-buttons and slide switches, for use in the Qsys system. It generalises the plain key/switch PIO with four features:
- configurable channel count;
- per-channel synchroniser and debouncer;
- per-channel selectable edge capture;
- a maskable level interrupt.

It sits between the raw FPGA pins (`keys`, `switches`) and the Nios II data master.

---
 rtl/key_pio_pkg.sv | 12 +
 rtl/key_debounce.sv | 56 +++++
 rtl/key_pio_debounced.sv | 80 ++++++++
 tb/tb_key_pio_debounced.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/key_pio_pkg.sv
// Shared constants for the debounced key/switch PIO: register addresses and
// the widest channel count the 32-bit data bus can carry.
package key_pio_pkg;

    localparam int MAX_WIDTH = 32;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd2;
    localparam logic [1:0] ADDR_EDGESEL = 2'd3;

endpackage

// File: rtl/key_debounce.sv
// One input channel: two-flop synchroniser followed, when KEY_PIO_DEBOUNCE_EN
// is defined, by a stability counter that gates updates of the accepted level.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic stable
);

    logic sync1;
    logic sync2;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= IDLE_LEVEL;
            sync2 <= IDLE_LEVEL;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

`ifdef KEY_PIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             stable_q;

    // Any cycle where the synchronised level agrees with stable restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            stable_q <= IDLE_LEVEL;
        end else if (sync2 != stable_q) begin
            if (cnt == CNT_LAST) begin
                stable_q <= sync2;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    assign stable = stable_q;
`else
    assign stable = sync2;
`endif

endmodule

// File: rtl/key_pio_debounced.sv
// Avalon-MM input PIO with per-channel debounce, edge capture and maskable irq.
// Debounce counters are built only when KEY_PIO_DEBOUNCE_EN is defined.
module key_pio_debounced
    import key_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins_in,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq
);

    logic [WIDTH-1:0]     stable;
    logic [WIDTH-1:0]     stable_d;
    logic [WIDTH-1:0]     irq_mask;
    logic [WIDTH-1:0]     edge_cap;
    logic [WIDTH-1:0]     edge_sel;
    logic [WIDTH-1:0]     edge_hit;
    logic [WIDTH-1:0]     cap_clr;
    logic [WIDTH-1:0]     wdata;
    logic [MAX_WIDTH-1:0] rd_next;
    wire                  unused_wdata = &{1'b0, avs_writedata};

    assign wdata = avs_writedata[WIDTH-1:0];

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .IDLE_LEVEL     (IDLE_LEVEL)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .pin   (pins_in[i]),
            .stable(stable[i])
        );
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        edge_hit = (edge_sel & stable & ~stable_d) | (~edge_sel & ~stable & stable_d);
        cap_clr  = '0;
        if (avs_write && avs_address == ADDR_EDGECAP) cap_clr = wdata;

        rd_next = '0;
        case (avs_address)
            ADDR_DATA:    rd_next[WIDTH-1:0] = stable;
            ADDR_IRQMASK: rd_next[WIDTH-1:0] = irq_mask;
            ADDR_EDGECAP: rd_next[WIDTH-1:0] = edge_cap;
            default:      rd_next[WIDTH-1:0] = edge_sel;
        endcase
    end

    // Set is OR-ed in after the clear so a coinciding edge survives the W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d     <= {WIDTH{IDLE_LEVEL}};
            irq_mask     <= '0;
            edge_cap     <= '0;
            edge_sel     <= '0;
            avs_readdata <= '0;
        end else begin
            stable_d <= stable;
            edge_cap <= (edge_cap & ~cap_clr) | edge_hit;
            if (avs_write && avs_address == ADDR_IRQMASK) irq_mask <= wdata;
            if (avs_write && avs_address == ADDR_EDGESEL) edge_sel <= wdata;
            if (avs_read) avs_readdata <= rd_next;
        end
    end

    assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_key_pio_debounced.sv
// Directed bench for key_pio_debounced: register table plus timed edge, W1C and
// reset sequences. Expectations track KEY_PIO_DEBOUNCE_EN when it is defined.
module tb_key_pio_debounced;
    import key_pio_pkg::*;

    localparam int DEB = 8;
`ifdef KEY_PIO_DEBOUNCE_EN
    localparam int LAT = 2 + DEB;
    localparam bit HAS_DEB = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit HAS_DEB = 1'b0;
`endif

    typedef enum int {OP_RD, OP_WR, OP_RW} op_e;
    typedef struct {
        op_e         op;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        exp_irq;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  pins_in;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_pio_debounced #(.WIDTH(4), .DEBOUNCE_CYCLES(DEB), .IDLE_LEVEL(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .pins_in      (pins_in),
        .avs_address  (avs_address),
        .avs_read     (avs_read),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata (avs_readdata),
        .irq          (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        step(1);
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        step(1);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    vec_t        vecs[16];
    logic [31:0] rd;

    initial begin
        vecs[0]  = '{OP_RD, ADDR_DATA,    32'h0,         32'hF, 1'b0};
        vecs[1]  = '{OP_RD, ADDR_IRQMASK, 32'h0,         32'h0, 1'b0};
        vecs[2]  = '{OP_RD, ADDR_EDGECAP, 32'h0,         32'h0, 1'b0};
        vecs[3]  = '{OP_RD, ADDR_EDGESEL, 32'h0,         32'h0, 1'b0};
        vecs[4]  = '{OP_WR, ADDR_IRQMASK, 32'hFFFF_FFF5, 32'h0, 1'b0};
        vecs[5]  = '{OP_RD, ADDR_IRQMASK, 32'h0,         32'h5, 1'b0};
        vecs[6]  = '{OP_RW, ADDR_IRQMASK, 32'hA,         32'h5, 1'b0};
        vecs[7]  = '{OP_RD, ADDR_IRQMASK, 32'h0,         32'hA, 1'b0};
        vecs[8]  = '{OP_RD, ADDR_IRQMASK, 32'hF,         32'hA, 1'b0};
        vecs[9]  = '{OP_WR, ADDR_EDGESEL, 32'h3C,        32'h0, 1'b0};
        vecs[10] = '{OP_RD, ADDR_EDGESEL, 32'h0,         32'hC, 1'b0};
        vecs[11] = '{OP_WR, ADDR_EDGECAP, 32'hF,         32'h0, 1'b0};
        vecs[12] = '{OP_RD, ADDR_EDGECAP, 32'h0,         32'h0, 1'b0};
        vecs[13] = '{OP_WR, ADDR_DATA,    32'h0,         32'h0, 1'b0};
        vecs[14] = '{OP_RD, ADDR_DATA,    32'h0,         32'hF, 1'b0};
        vecs[15] = '{OP_WR, ADDR_EDGESEL, 32'h0,         32'h0, 1'b0};

        reset = 1'b1; pins_in = 4'hF; avs_address = '0;
        avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_readdata", avs_readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);

        for (int i = 0; i < 16; i++) begin
            avs_address   = vecs[i].addr;
            avs_writedata = vecs[i].wdata;
            avs_read      = (vecs[i].op != OP_WR);
            avs_write     = (vecs[i].op != OP_RD);
            step(1);
            avs_read = 1'b0; avs_write = 1'b0;
            if (vecs[i].op != OP_WR)
                check($sformatf("vec%0d_read", i), avs_readdata, vecs[i].exp);
            check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
        end
        bus_write(ADDR_IRQMASK, 32'h0);

        // Five-cycle glitch on channel 0
        pins_in[0] = 1'b0;
        step(5);
        pins_in[0] = 1'b1;
        step(LAT + 4);
        bus_read(ADDR_DATA, rd);
        check("bounce_data", rd, 32'hF);
        bus_read(ADDR_EDGECAP, rd);
        check("bounce_edgecap", rd, HAS_DEB ? 32'h0 : 32'h1);
        bus_write(ADDR_EDGECAP, 32'h1);

        // Debounced falling edge with exact latency
        bus_write(ADDR_IRQMASK, 32'h1);
        bus_write(ADDR_EDGESEL, 32'h0);
        pins_in[0] = 1'b0;
        step(LAT);
        check("fall_irq_early", {31'b0, irq}, 32'h0);
        step(1);
        check("fall_irq_set", {31'b0, irq}, 32'h1);
        bus_read(ADDR_DATA, rd);
        check("fall_data", rd, 32'hE);
        bus_read(ADDR_EDGECAP, rd);
        check("fall_edgecap", rd, 32'h1);
        bus_write(ADDR_EDGECAP, 32'h1);
        check("fall_w1c_irq", {31'b0, irq}, 32'h0);
        pins_in[0] = 1'b1;
        step(LAT + 2);
        bus_read(ADDR_EDGECAP, rd);
        check("fall_release_ignored", rd, 32'h0);

        // Rising select on channel 1
        bus_write(ADDR_EDGESEL, 32'h2);
        bus_write(ADDR_IRQMASK, 32'h3);
        pins_in[1] = 1'b0;
        step(LAT + 4);
        bus_read(ADDR_EDGECAP, rd);
        check("rise_press_ignored", rd, 32'h0);
        pins_in[1] = 1'b1;
        step(LAT);
        check("rise_irq_early", {31'b0, irq}, 32'h0);
        step(1);
        check("rise_irq_set", {31'b0, irq}, 32'h1);
        bus_read(ADDR_EDGECAP, rd);
        check("rise_edgecap", rd, 32'h2);

        // W1C lands on the same edge that captures a new rising edge
        pins_in[1] = 1'b0;
        step(LAT + 4);
        pins_in[1] = 1'b1;
        step(LAT);
        bus_write(ADDR_EDGECAP, 32'h2);
        check("same_cycle_irq", {31'b0, irq}, 32'h1);
        bus_read(ADDR_EDGECAP, rd);
        check("same_cycle_edgecap", rd, 32'h2);
        bus_write(ADDR_EDGECAP, 32'h2);
        check("w1c_after_irq", {31'b0, irq}, 32'h0);

        // Reset part-way through a debounce count
        pins_in[0] = 1'b0;
        step(2 + 4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("midreset_readdata", avs_readdata, 32'h0);
        check("midreset_irq", {31'b0, irq}, 32'h0);
        bus_read(ADDR_DATA, rd);
        check("midreset_data", rd, 32'hF);
        bus_read(ADDR_EDGECAP, rd);
        check("midreset_edgecap", rd, 32'h0);
        if (HAS_DEB) begin
            step(DEB - 1);
            bus_read(ADDR_DATA, rd);
            check("midreset_full_count", rd, 32'hF);
        end
        bus_read(ADDR_DATA, rd);
        check("midreset_data_final", rd, 32'hE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
